// File: rtl/mem_access_initiator.sv
// Requester-side controller for the byte-lane data RAM: accepts one load/store,
// drives the RAM for one cycle, waits out read latency, returns an extended result.
module mem_access_initiator #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic [3:0]        mem_byte_enablers,
  output logic              mem_write_enable,
  input  logic [31:0]       mem_data_out
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LATENCY - 1);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [1:0]        size_q, size_n;
  logic              signed_q, signed_n;
  logic              write_q, write_n;

  logic              req_ready_n;
  logic              rsp_valid_n;
  logic [DATA_W-1:0] rsp_rdata_n;
  logic              rsp_error_n;
  logic [ADDR_W-1:0] mem_address_n;
  logic [DATA_W-1:0] mem_data_in_n;
  logic [BE_W-1:0]   mem_byte_enablers_n;
  logic              mem_write_enable_n;

  // Lane-0-justified enablers; the RAM rotates them for unaligned addresses.
  function automatic logic [BE_W-1:0] size_to_be(input logic [1:0] sz);
    case (sz)
      SIZE_BYTE: size_to_be = 4'b0001;
      SIZE_HALF: size_to_be = 4'b0011;
      default:   size_to_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                                input logic [1:0] sz,
                                                input logic sg);
    case (sz)
      SIZE_BYTE: extend = {{24{sg & d[7]}}, d[7:0]};
      SIZE_HALF: extend = {{16{sg & d[15]}}, d[15:0]};
      default:   extend = d;
    endcase
  endfunction

  // Next state and next registered outputs; everything holds unless changed.
  always_comb begin
    state_n             = state;
    cnt_n               = cnt;
    size_n              = size_q;
    signed_n            = signed_q;
    write_n             = write_q;
    req_ready_n         = req_ready;
    rsp_valid_n         = rsp_valid;
    rsp_rdata_n         = rsp_rdata;
    rsp_error_n         = rsp_error;
    mem_address_n       = mem_address;
    mem_data_in_n       = mem_data_in;
    mem_byte_enablers_n = mem_byte_enablers;
    mem_write_enable_n  = mem_write_enable;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          req_ready_n = 1'b0;
          size_n      = req_size;
          signed_n    = req_signed;
          write_n     = req_write;
          if (req_size == SIZE_ILL) begin
            state_n     = S_RESP;
            rsp_valid_n = 1'b1;
            rsp_error_n = 1'b1;
            rsp_rdata_n = '0;
          end else begin
            state_n             = S_ACCESS;
            mem_address_n       = req_address;
            mem_data_in_n       = req_wdata;
            mem_byte_enablers_n = size_to_be(req_size);
            mem_write_enable_n  = req_write;
          end
        end
      end

      S_ACCESS: begin
        mem_write_enable_n = 1'b0;
        if (write_q) begin
          state_n             = S_RESP;
          mem_byte_enablers_n = '0;
          rsp_valid_n         = 1'b1;
          rsp_error_n         = 1'b0;
          rsp_rdata_n         = '0;
        end else begin
          state_n = S_WAIT;
          cnt_n   = CNT_LOAD;
        end
      end

      // Address and enablers stay on the RAM until read data is captured.
      S_WAIT: begin
        if (cnt == '0) begin
          state_n             = S_RESP;
          mem_byte_enablers_n = '0;
          rsp_valid_n         = 1'b1;
          rsp_error_n         = 1'b0;
          rsp_rdata_n         = extend(mem_data_out, size_q, signed_q);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_n     = S_IDLE;
          rsp_valid_n = 1'b0;
          req_ready_n = 1'b1;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      cnt               <= '0;
      size_q            <= '0;
      signed_q          <= 1'b0;
      write_q           <= 1'b0;
      req_ready         <= 1'b1;
      rsp_valid         <= 1'b0;
      rsp_rdata         <= '0;
      rsp_error         <= 1'b0;
      mem_address       <= '0;
      mem_data_in       <= '0;
      mem_byte_enablers <= '0;
      mem_write_enable  <= 1'b0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      size_q            <= size_n;
      signed_q          <= signed_n;
      write_q           <= write_n;
      req_ready         <= req_ready_n;
      rsp_valid         <= rsp_valid_n;
      rsp_rdata         <= rsp_rdata_n;
      rsp_error         <= rsp_error_n;
      mem_address       <= mem_address_n;
      mem_data_in       <= mem_data_in_n;
      mem_byte_enablers <= mem_byte_enablers_n;
      mem_write_enable  <= mem_write_enable_n;
    end
  end

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed bench: two initiators (RAM latency 1 and 3), each with its own byte-lane RAM model.
module tb_mem_access_initiator;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid   [2];
  logic        req_ready   [2];
  logic        req_write   [2];
  logic [1:0]  req_size    [2];
  logic        req_signed  [2];
  logic [17:0] req_address [2];
  logic [31:0] req_wdata   [2];
  logic        rsp_valid   [2];
  logic        rsp_ready   [2];
  logic [31:0] rsp_rdata   [2];
  logic        rsp_error   [2];
  logic [17:0] maddr       [2];
  logic [31:0] mdin        [2];
  logic [3:0]  mbe         [2];
  logic        mwe         [2];
  logic [31:0] mdout       [2];

  logic [7:0]  ram  [2][1024];
  logic [31:0] pipe [2][4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_access_initiator #(.ADDR_W(18), .RAM_LATENCY(1)) u_lat1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_address(req_address[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]), .mem_address(maddr[0]),
    .mem_data_in(mdin[0]), .mem_byte_enablers(mbe[0]), .mem_write_enable(mwe[0]),
    .mem_data_out(mdout[0])
  );

  mem_access_initiator #(.ADDR_W(18), .RAM_LATENCY(3)) u_lat3 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_address(req_address[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]), .mem_address(maddr[1]),
    .mem_data_in(mdin[1]), .mem_byte_enablers(mbe[1]), .mem_write_enable(mwe[1]),
    .mem_data_out(mdout[1])
  );

  // RAM model: lane-0-justified bytes at address+i, read pipelined by latency.
  function automatic logic [31:0] ram_rd(input int d, input logic [17:0] a);
    ram_rd = {ram[d][10'(a + 18'd3)], ram[d][10'(a + 18'd2)],
              ram[d][10'(a + 18'd1)], ram[d][10'(a)]};
  endfunction

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (mwe[d])
        for (int i = 0; i < 4; i++)
          if (mbe[d][i]) ram[d][10'(maddr[d] + 18'(i))] <= mdin[d][8*i +: 8];
      pipe[d][0] <= ram_rd(d, maddr[d]);
      for (int k = 1; k < 4; k++) pipe[d][k] <= pipe[d][k-1];
    end
  end

  assign mdout[0] = pipe[0][0];
  assign mdout[1] = pipe[1][2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input int d, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [17:0] a, input logic [31:0] wd);
    req_write[d]   = wr;
    req_size[d]    = sz;
    req_signed[d]  = sg;
    req_address[d] = a;
    req_wdata[d]   = wd;
    req_valid[d]   = 1'b1;
    step();
    req_valid[d]   = 1'b0;
  endtask

  task automatic do_store(input int d, input logic [1:0] sz, input logic [17:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
    issue(d, 1'b1, sz, 1'b0, a, wd);
    chk("st_we_on", 32'(mwe[d]), 32'd1);
    chk("st_be", 32'(mbe[d]), 32'(be));
    chk("st_addr", 32'(maddr[d]), 32'(a));
    chk("st_din", mdin[d], wd);
    chk("st_rdy_low", 32'(req_ready[d]), 32'd0);
    chk("st_no_rsp_yet", 32'(rsp_valid[d]), 32'd0);
    step();
    chk("st_we_off", 32'(mwe[d]), 32'd0);
    chk("st_be_off", 32'(mbe[d]), 32'd0);
    chk("st_rsp", 32'(rsp_valid[d]), 32'd1);
    chk("st_rdata", rsp_rdata[d], 32'd0);
    chk("st_err", 32'(rsp_error[d]), 32'd0);
    step();
    chk("st_done", 32'(rsp_valid[d]), 32'd0);
    chk("st_rdy_back", 32'(req_ready[d]), 32'd1);
  endtask

  task automatic do_load(input int d, input logic [1:0] sz, input logic sg, input logic [17:0] a,
                         input int lat, input logic [3:0] be, input logic [31:0] exp);
    int n;
    issue(d, 1'b0, sz, sg, a, 32'h0);
    chk("ld_be", 32'(mbe[d]), 32'(be));
    chk("ld_we", 32'(mwe[d]), 32'd0);
    chk("ld_addr", 32'(maddr[d]), 32'(a));
    n = 0;
    while (!rsp_valid[d] && n < 20) begin
      step();
      n++;
    end
    chk("ld_latency", 32'(n), 32'(1 + lat));
    chk("ld_rdata", rsp_rdata[d], exp);
    chk("ld_err", 32'(rsp_error[d]), 32'd0);
    step();
    chk("ld_done", 32'(rsp_valid[d]), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'b00;
      req_signed[d] = 1'b0; req_address[d] = '0; req_wdata[d] = '0;
      rsp_ready[d] = 1'b1;
    end
    reset = 1'b0;
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
      chk("rst_rsp_error", 32'(rsp_error[d]), 32'd0);
      chk("rst_mem_addr", 32'(maddr[d]), 32'd0);
      chk("rst_mem_din", mdin[d], 32'd0);
      chk("rst_mem_be", 32'(mbe[d]), 32'd0);
      chk("rst_mem_we", 32'(mwe[d]), 32'd0);
    end
    reset = 1'b1;
    step();

    // Reset in the middle of a store's access cycle.
    issue(0, 1'b1, 2'b10, 1'b0, 18'h00300, 32'h11111111);
    chk("mid_we_before", 32'(mwe[0]), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_we_async_drop", 32'(mwe[0]), 32'd0);
    chk("mid_rsp_none", 32'(rsp_valid[0]), 32'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_rsp_after", 32'(rsp_valid[0]), 32'd0);
    end
    chk("mid_rdy_after", 32'(req_ready[0]), 32'd1);

    // Word store then load, latency 1.
    do_store(0, 2'b10, 18'h00104, 32'hDEADBEEF, 4'b1111);
    do_load(0, 2'b10, 1'b0, 18'h00104, 1, 4'b1111, 32'hDEADBEEF);

    // Byte / half extension from 0x1234F680 at 0x00200.
    do_store(0, 2'b10, 18'h00200, 32'h1234F680, 4'b1111);
    do_load(0, 2'b00, 1'b1, 18'h00200, 1, 4'b0001, 32'hFFFFFF80);
    do_load(0, 2'b00, 1'b0, 18'h00200, 1, 4'b0001, 32'h00000080);
    do_load(0, 2'b01, 1'b1, 18'h00200, 1, 4'b0011, 32'hFFFFF680);
    do_load(0, 2'b01, 1'b0, 18'h00200, 1, 4'b0011, 32'h0000F680);
    do_load(0, 2'b10, 1'b1, 18'h00200, 1, 4'b1111, 32'h1234F680);

    // Unaligned half store straddling a word boundary.
    do_store(0, 2'b10, 18'h00204, 32'h00000000, 4'b1111);
    do_store(0, 2'b01, 18'h00203, 32'h0000ABCD, 4'b0011);
    do_load(0, 2'b10, 1'b0, 18'h00200, 1, 4'b1111, 32'hCD34F680);
    do_load(0, 2'b10, 1'b0, 18'h00204, 1, 4'b1111, 32'h000000AB);

    // Wrap-around address passes through untouched.
    do_store(0, 2'b00, 18'h3FFFF, 32'h0000005A, 4'b0001);
    do_load(0, 2'b00, 1'b1, 18'h3FFFF, 1, 4'b0001, 32'h0000005A);

    // Illegal size: immediate error response, no RAM access.
    issue(0, 1'b1, 2'b11, 1'b0, 18'h00010, 32'hFFFFFFFF);
    chk("ill_rsp", 32'(rsp_valid[0]), 32'd1);
    chk("ill_err", 32'(rsp_error[0]), 32'd1);
    chk("ill_rdata", rsp_rdata[0], 32'd0);
    chk("ill_we", 32'(mwe[0]), 32'd0);
    chk("ill_be", 32'(mbe[0]), 32'd0);
    chk("ill_addr_held", 32'(maddr[0]), 32'h3FFFF);
    step();
    chk("ill_done", 32'(rsp_valid[0]), 32'd0);
    chk("ill_rdy", 32'(req_ready[0]), 32'd1);

    // Latency 3 with response backpressure.
    do_store(1, 2'b10, 18'h00040, 32'hCAFEF00D, 4'b1111);
    do_load(1, 2'b01, 1'b1, 18'h00040, 3, 4'b0011, 32'hFFFFF00D);
    rsp_ready[1] = 1'b0;
    begin
      int n;
      issue(1, 1'b0, 2'b10, 1'b0, 18'h00040, 32'h0);
      n = 0;
      while (!rsp_valid[1] && n < 20) begin
        step();
        n++;
      end
      chk("bp_latency", 32'(n), 32'd4);
      for (int i = 0; i < 5; i++) begin
        step();
        chk("bp_valid_held", 32'(rsp_valid[1]), 32'd1);
        chk("bp_rdata_held", rsp_rdata[1], 32'hCAFEF00D);
        chk("bp_rdy_low", 32'(req_ready[1]), 32'd0);
      end
      rsp_ready[1] = 1'b1;
      step();
      chk("bp_done", 32'(rsp_valid[1]), 32'd0);
      chk("bp_rdy_back", 32'(req_ready[1]), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
